// File: rtl/shift_pipe_ctrl.sv
// shift_pipe_ctrl: valid/enable sequencing for a DEPTH-stage shift-register
// chain. The data registers stay in the datapath. This block tracks which
// stages hold tokens, collapses bubbles, and runs drain and flush.
module shift_pipe_ctrl #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  input  logic               drain_req,
  output logic               drain_done,
  output logic [DEPTH-1:0]   stage_en,
  output logic [DEPTH-1:0]   stage_vld,
  output logic [OCC_W-1:0]   occupancy,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] adv;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             in_fire, out_fire;

  // Advance chain: a stage may load when it is empty or everything below it moves.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !vld_q[DEPTH-1] || out_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = !vld_q[DEPTH-1-k] || adv[DEPTH-k];
    end
  end

  // Next valid bits, occupancy and transfer count.
  always_comb begin
    out_fire = vld_q[DEPTH-1] && out_ready;
    vld_d    = vld_q;
    if (flush) begin
      vld_d = '0;
    end else begin
      if (adv[0]) vld_d[0] = in_fire;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (adv[k]) vld_d[k] = vld_q[k-1];
      end
    end
    occ_d = flush ? '0 : (occ_q + OCC_W'(in_fire) - OCC_W'(out_fire));
    cnt_d = cnt_q + CNT_W'(out_fire);
  end

  // Chain state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  // FSM state register, plus the registered one-cycle drain_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // FSM next state: flush > drain_req > normal sequencing.
  // A drain requested on an empty chain still passes through one DRAIN cycle.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (drain_req)    state_d = DRAIN;
          else if (in_fire) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (drain_req)       state_d = DRAIN;
          else if (occ_d == '0) state_d = IDLE;
        end
        DRAIN: begin
          if (occ_d == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: input handshake, stage enables, drain completion.
  always_comb begin
    in_ready = rst_n && adv[0] && (state_q != DRAIN) && !flush && !drain_req;
    in_fire  = in_valid && in_ready;
    stage_en = '0;
    stage_en[0] = in_fire;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_en[k] = adv[k] && vld_q[k-1] && !flush;
    end
    done_d = !flush && (state_q == DRAIN) && (occ_d == '0);
  end

  assign out_valid  = vld_q[DEPTH-1];
  assign stage_vld  = vld_q;
  assign occupancy  = occ_q;
  assign state      = state_q;
  assign xfer_cnt   = cnt_q;
  assign drain_done = done_q;

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
// Bench for shift_pipe_ctrl (DEPTH=3, CNT_W=8): directed vector table,
// multi-cycle corner sequences, then random stimulus against a token model.
module tb_shift_pipe_ctrl;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, flush, drain_req;
  logic       in_ready, out_valid, drain_done;
  logic [2:0] stage_en, stage_vld;
  logic [1:0] occupancy;
  logic [1:0] state;
  logic [7:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  shift_pipe_ctrl #(.DEPTH(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .drain_req(drain_req), .drain_done(drain_done), .stage_en(stage_en),
    .stage_vld(stage_vld), .occupancy(occupancy), .state(state),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 0; out_ready = 0; flush = 0; drain_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic iv, ordy, fl, dr;
    logic exp_rdy;
    logic [2:0] exp_vld;
    int exp_occ, exp_st;
    logic exp_done;
    int exp_cnt;
  } vec_t;

  vec_t tbl[28];

  // Token model: stage i moves when any stage at or below it is empty, or the
  // consumer takes the last one.
  logic [2:0] m_vld;
  int m_state, m_done, m_cnt;

  function automatic logic m_adv(int i, logic ordy);
    for (int j = i; j < D; j++) if (!m_vld[j]) return 1'b1;
    return ordy;
  endfunction

  initial begin
    int edges;
    // iv or fl dr | rdy vld occ st done cnt
    tbl[0]  = '{1,0,0,0, 1,3'b001,1,1,0,0};
    tbl[1]  = '{1,0,0,0, 1,3'b011,2,1,0,0};
    tbl[2]  = '{1,0,0,0, 1,3'b111,3,1,0,0};
    tbl[3]  = '{1,0,0,0, 0,3'b111,3,1,0,0};
    tbl[4]  = '{0,1,0,0, 1,3'b110,2,1,0,1};
    tbl[5]  = '{0,0,0,0, 1,3'b110,2,1,0,1};
    tbl[6]  = '{0,1,0,0, 1,3'b100,1,1,0,2};
    tbl[7]  = '{0,1,0,0, 1,3'b000,0,0,0,3};
    tbl[8]  = '{1,0,0,0, 1,3'b001,1,1,0,3};
    tbl[9]  = '{0,0,0,0, 1,3'b010,1,1,0,3};
    tbl[10] = '{1,0,0,0, 1,3'b101,2,1,0,3};
    tbl[11] = '{0,0,0,0, 1,3'b110,2,1,0,3};
    tbl[12] = '{1,0,1,0, 0,3'b000,0,0,0,3};
    tbl[13] = '{1,0,0,0, 1,3'b001,1,1,0,3};
    tbl[14] = '{1,0,0,0, 1,3'b011,2,1,0,3};
    tbl[15] = '{1,1,0,1, 0,3'b110,2,2,0,3};
    tbl[16] = '{1,1,0,0, 0,3'b100,1,2,0,4};
    tbl[17] = '{1,1,0,0, 0,3'b000,0,0,1,5};
    tbl[18] = '{0,0,0,0, 1,3'b000,0,0,0,5};
    tbl[19] = '{0,0,0,1, 0,3'b000,0,2,0,5};
    tbl[20] = '{0,0,0,0, 0,3'b000,0,0,1,5};
    tbl[21] = '{0,0,0,0, 1,3'b000,0,0,0,5};
    tbl[22] = '{1,0,0,0, 1,3'b001,1,1,0,5};
    tbl[23] = '{1,0,0,0, 1,3'b011,2,1,0,5};
    tbl[24] = '{1,0,0,0, 1,3'b111,3,1,0,5};
    tbl[25] = '{0,0,0,1, 0,3'b111,3,2,0,5};
    tbl[26] = '{0,0,1,0, 0,3'b000,0,0,0,5};
    tbl[27] = '{0,0,0,0, 1,3'b000,0,0,0,5};

    do_reset();
    #1;
    chk("rst_vld", stage_vld, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_state", state, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_done", drain_done, 0);

    // Directed table.
    foreach (tbl[n]) begin
      @(negedge clk);
      in_valid = tbl[n].iv; out_ready = tbl[n].ordy;
      flush = tbl[n].fl; drain_req = tbl[n].dr;
      #1 chk($sformatf("tbl%0d_rdy", n), in_ready, tbl[n].exp_rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_vld", n), stage_vld, tbl[n].exp_vld);
      chk($sformatf("tbl%0d_occ", n), occupancy, tbl[n].exp_occ);
      chk($sformatf("tbl%0d_st", n), state, tbl[n].exp_st);
      chk($sformatf("tbl%0d_done", n), drain_done, tbl[n].exp_done);
      chk($sformatf("tbl%0d_cnt", n), xfer_cnt, tbl[n].exp_cnt);
    end

    // Latency: one token on an empty chain reaches the output after 3 edges.
    do_reset();
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency_edges", edges, 3);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    chk("latency_cnt", xfer_cnt, 1);
    chk("latency_empty", out_valid, 0);

    // Full streaming: fill, then 20 cycles of simultaneous in/out.
    do_reset();
    in_valid = 1;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); out_ready = 1; in_valid = 1;
      #1 chk("stream_rdy", in_ready, 1);
      chk("stream_en", stage_en, 3'b111);
      @(posedge clk); #1 chk("stream_occ", occupancy, 3);
    end
    chk("stream_cnt", xfer_cnt, 20);

    // Async reset mid-operation clears everything at once.
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_ovld", out_valid, 0);
    chk("arst_vld", stage_vld, 0);
    chk("arst_rdy", in_ready, 0);
    chk("arst_en", stage_en, 0);
    chk("arst_occ", occupancy, 0);
    chk("arst_cnt", xfer_cnt, 0);
    chk("arst_st", state, 0);

    // Random phase against the model.
    do_reset();
    m_vld = '0; m_state = 0; m_done = 0; m_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      logic rdy, ifire, ofire;
      logic [2:0] en, nv;
      int occ_n;
      @(negedge clk);
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(39) == 0);
      drain_req = ($urandom_range(24) == 0);
      #1;
      rdy = m_adv(0, out_ready) && (m_state != 2) && !flush && !drain_req;
      ifire = in_valid && rdy;
      ofire = m_vld[D-1] && out_ready;
      en[0] = ifire;
      for (int i = 1; i < D; i++) en[i] = m_adv(i, out_ready) && m_vld[i-1] && !flush;
      chk("rnd_rdy", in_ready, rdy);
      chk("rnd_en", stage_en, en);
      chk("rnd_vld", stage_vld, m_vld);
      chk("rnd_ovld", out_valid, m_vld[D-1]);
      chk("rnd_occ", occupancy, $countones(m_vld));
      chk("rnd_st", state, m_state);
      chk("rnd_done", drain_done, m_done);
      chk("rnd_cnt", xfer_cnt, m_cnt);
      // Next model state.
      nv = '0;
      if (!flush)
        for (int i = 0; i < D; i++)
          nv[i] = m_adv(i, out_ready) ? ((i == 0) ? ifire : m_vld[i-1]) : m_vld[i];
      occ_n = $countones(nv);
      if (ofire) m_cnt = (m_cnt + 1) % 256;
      m_done = 0;
      if (flush) m_state = 0;
      else if (m_state == 0) begin
        if (drain_req) m_state = 2; else if (ifire) m_state = 1;
      end else if (m_state == 1) begin
        if (drain_req) m_state = 2; else if (occ_n == 0) m_state = 0;
      end else if (occ_n == 0) begin
        m_state = 0; m_done = 1;
      end
      m_vld = nv;
      @(posedge clk);
    end
    #1;
    chk("rnd_final_vld", stage_vld, m_vld);
    chk("rnd_final_cnt", xfer_cnt, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
